// File: rtl/cmd_frame_pkg.sv
// Shared frame constants, state and error encodings for the command frame parser and executor.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cmd_frame_pkg;

    localparam logic [7:0] HDR_WR = 8'h5A;
    localparam logic [7:0] HDR_RD = 8'h5B;

    // header + 4 address bytes + 4 data bytes + tail
    localparam int FRAME_LEN   = 10;
    localparam int FIELD_BYTES = (FRAME_LEN - 2) / 2;
    localparam logic [1:0] LAST_IDX = 2'(FIELD_BYTES - 1);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_TAIL = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_HDR  = 2'b01,
        ERR_TAIL = 2'b10,
        ERR_TMO  = 2'b11
    } err_code_t;

    // A frame closes with the bitwise complement of its header byte.
    function automatic logic [7:0] tail_of(input logic [7:0] hdr);
        return ~hdr;
    endfunction

    function automatic logic is_hdr(input logic [7:0] b);
        return (b == HDR_WR) || (b == HDR_RD);
    endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte-stream input, decoded command output and error report of the command frame parser.
// Latency: n/a (signal bundle).
// Backpressure: DATA_STREAM_IN_ACK gates the byte stream, CMD_READY gates the command.
interface cmd_frame_parser_if;

    logic [7:0]  DATA_STREAM_IN;
    logic        DATA_STREAM_IN_STB;
    logic        DATA_STREAM_IN_ACK;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WR;
    logic [31:0] CMD_ADDR;
    logic [31:0] CMD_DATA;
    logic        FRAME_ERR;
    logic [1:0]  FRAME_ERR_CODE;

    // parser side
    modport master (
        input  DATA_STREAM_IN,
        input  DATA_STREAM_IN_STB,
        output DATA_STREAM_IN_ACK,
        output CMD_VALID,
        input  CMD_READY,
        output CMD_WR,
        output CMD_ADDR,
        output CMD_DATA,
        output FRAME_ERR,
        output FRAME_ERR_CODE
    );

    // receiver / executor side
    modport slave (
        output DATA_STREAM_IN,
        output DATA_STREAM_IN_STB,
        input  DATA_STREAM_IN_ACK,
        input  CMD_VALID,
        output CMD_READY,
        input  CMD_WR,
        input  CMD_ADDR,
        input  CMD_DATA,
        input  FRAME_ERR,
        input  FRAME_ERR_CODE
    );

endinterface

// File: rtl/frame_timeout_ctr.sv
// Inter-byte timeout: counts 2 kHz pulse rising edges while a frame is being assembled.
// Latency: edge seen on pulse_i is counted one cycle later; timeout_o is combinational from the count.
// Backpressure: none; an accepted byte always clears the count and suppresses a coincident timeout.
module frame_timeout_ctr #(
    parameter int TIMEOUT_TICKS = 4,
    parameter int TICK_W        = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pulse_i,
    input  logic active_i,
    input  logic byte_acc_i,
    output logic timeout_o
);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TIMEOUT_TICKS - 1);

    logic              pulse_q;
    logic              rise_q;
    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    // Registered rising-edge detect of the pulse input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            pulse_q <= pulse_i;
            rise_q  <= pulse_i & ~pulse_q;
        end
    end

    // The edge that would take the count to TIMEOUT_TICKS fires the timeout instead.
    assign timeout_o = active_i && rise_q && !byte_acc_i && (cnt_q == LAST_TICK);

    // Count edges only while assembling; any byte, idle state or expiry resets it.
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || byte_acc_i || timeout_o) begin
            cnt_d = '0;
        end else if (rise_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Tick counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles 10-byte host frames (hdr, addr[4], data[4], ~hdr) into one OPB read/write command.
// Latency: tail byte accepted in cycle N -> CMD_VALID at N+1; FRAME_ERR pulses the cycle after the cause.
// Backpressure: byte ACK held low while a command waits for CMD_READY; bytes resume 1 cycle after handshake.
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 4,
    parameter int TICK_W        = 4
) (
    input  logic SYS_CLK,
    input  logic SYS_RST,
    input  logic PULSE_2KHZ,
    cmd_frame_parser_if.master bus
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    err_code_t   code_q, code_d;

    logic        byte_acc;
    logic [7:0]  rx_byte;
    logic        tmo_active;
    logic        tmo;

    assign rx_byte    = bus.DATA_STREAM_IN;
    assign byte_acc   = bus.DATA_STREAM_IN_STB && ack_q;
    assign tmo_active = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_TAIL);

    frame_timeout_ctr #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .TICK_W        (TICK_W)
    ) u_tmo (
        .clk_i      (SYS_CLK),
        .rst_ni     (SYS_RST),
        .pulse_i    (PULSE_2KHZ),
        .active_i   (tmo_active),
        .byte_acc_i (byte_acc),
        .timeout_o  (tmo)
    );

    // Frame state machine: next state, field assembly, command hold and error reporting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        code_d  = code_q;

        case (state_q)
            S_HDR: begin
                if (byte_acc) begin
                    if (is_hdr(rx_byte)) begin
                        wr_d    = (rx_byte == HDR_WR);
                        addr_d  = '0;
                        // Cleared here and only shifted for writes, so reads present 0.
                        data_d  = '0;
                        idx_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_HDR;
                    end
                end
            end
            S_ADDR: begin
                if (byte_acc) begin
                    addr_d = {addr_q[23:0], rx_byte};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_acc) begin
                    if (wr_q) begin
                        data_d = {data_q[23:0], rx_byte};
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (byte_acc) begin
                    if (rx_byte == tail_of(wr_q ? HDR_WR : HDR_RD)) begin
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        // The bad tail is dropped, not retried as a header.
                        err_d   = 1'b1;
                        code_d  = ERR_TAIL;
                        state_d = S_HDR;
                    end
                end
            end
            S_HOLD: begin
                if (valid_q && bus.CMD_READY) begin
                    valid_d = 1'b0;
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase

        // Timeout is already masked by an accepted byte and by idle states.
        if (tmo) begin
            err_d   = 1'b1;
            code_d  = ERR_TMO;
            idx_d   = '0;
            state_d = S_HDR;
        end

        ack_d = (state_d != S_HOLD);
    end

    // State and output registers.
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            state_q <= S_HDR;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.DATA_STREAM_IN_ACK = ack_q;
    assign bus.CMD_VALID          = valid_q;
    assign bus.CMD_WR             = wr_q;
    assign bus.CMD_ADDR           = addr_q;
    assign bus.CMD_DATA           = data_q;
    assign bus.FRAME_ERR          = err_q;
    assign bus.FRAME_ERR_CODE     = code_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: per-cycle model comparison plus literal command/error checks.
// Latency: n/a.
// Backpressure: exercises a 1000-cycle CMD_READY stall with a queued byte.
module tb_cmd_frame_parser;

    localparam int TMO       = 4;
    localparam int PULSE_HALF = 20;
    localparam logic [79:0] WR_FRAME = 80'h5AAABBCCDD11223344A5;
    localparam logic [79:0] RD_FRAME = 80'h5B12345678AABBCCDDA4;
    localparam logic [79:0] BAD_TAIL = 80'h5AAABBCCDD11223344A4;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic pulse   = 1'b0;

    int checks = 0;
    int errors = 0;

    cmd_frame_parser_if bus ();

    cmd_frame_parser #(
        .TIMEOUT_TICKS (TMO),
        .TICK_W        (4)
    ) dut (
        .SYS_CLK    (sys_clk),
        .SYS_RST    (sys_rst),
        .PULSE_2KHZ (pulse),
        .bus        (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Scaled-down square wave, changed just after the active edge.
    initial begin
        forever begin
            repeat (PULSE_HALF) @(posedge sys_clk);
            #1 pulse = ~pulse;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mbuf[$];
    int          mticks;
    bit          mhold, mpend, mprev;
    logic        exp_ack, exp_valid, exp_wr, exp_err;
    logic [31:0] exp_addr, exp_data;
    logic [1:0]  exp_code;

    // observed traffic for literal checks
    logic        cap_wr[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [1:0]  err_codes[$];

    task automatic model_reset();
        mbuf.delete();
        mticks = 0; mhold = 0; mpend = 0; mprev = 0;
        exp_ack = 1'b1; exp_valid = 1'b0; exp_wr = 1'b0; exp_err = 1'b0;
        exp_addr = '0; exp_data = '0; exp_code = 2'b00;
    endtask

    task automatic model_flag(input logic [1:0] c);
        exp_err  = 1'b1;
        exp_code = c;
    endtask

    // Predict outputs after the coming clock edge from the inputs now applied.
    task automatic model_step();
        bit         acc, tick;
        logic [7:0] b, tail;
        acc  = bus.DATA_STREAM_IN_STB && exp_ack;
        b    = bus.DATA_STREAM_IN;
        tick = mpend;
        mpend = pulse && !mprev;
        mprev = pulse;
        exp_err = 1'b0;
        if (mhold) begin
            if (bus.CMD_READY) begin
                exp_valid = 1'b0;
                mhold     = 0;
            end
        end else if (acc) begin
            mticks = 0;
            if (mbuf.size() == 0) begin
                if (b == 8'h5A || b == 8'h5B) mbuf.push_back(b);
                else model_flag(2'b01);
            end else if (mbuf.size() < 9) begin
                mbuf.push_back(b);
            end else begin
                tail = ~mbuf[0];
                if (b == tail) begin
                    exp_wr    = (mbuf[0] == 8'h5A);
                    exp_addr  = {mbuf[1], mbuf[2], mbuf[3], mbuf[4]};
                    exp_data  = exp_wr ? {mbuf[5], mbuf[6], mbuf[7], mbuf[8]} : 32'h0;
                    exp_valid = 1'b1;
                    mhold     = 1;
                end else begin
                    model_flag(2'b10);
                end
                mbuf.delete();
            end
        end else if (mbuf.size() != 0) begin
            if (tick) mticks++;
            if (mticks == TMO) begin
                model_flag(2'b11);
                mbuf.delete();
                mticks = 0;
            end
        end
        exp_ack = !mhold;
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge sys_clk) begin
        if (!sys_rst) model_reset();
        chk("ack", 32'(bus.DATA_STREAM_IN_ACK), 32'(exp_ack));
        chk("valid", 32'(bus.CMD_VALID), 32'(exp_valid));
        chk("frame_err", 32'(bus.FRAME_ERR), 32'(exp_err));
        chk("err_code", 32'(bus.FRAME_ERR_CODE), 32'(exp_code));
        if (exp_valid) begin
            chk("cmd_wr", 32'(bus.CMD_WR), 32'(exp_wr));
            chk("cmd_addr", bus.CMD_ADDR, exp_addr);
            chk("cmd_data", bus.CMD_DATA, exp_data);
        end
        if (!sys_rst) begin
            chk("rst_wr", 32'(bus.CMD_WR), 32'h0);
            chk("rst_addr", bus.CMD_ADDR, 32'h0);
            chk("rst_data", bus.CMD_DATA, 32'h0);
        end else begin
            if (bus.CMD_VALID && bus.CMD_READY) begin
                cap_wr.push_back(bus.CMD_WR);
                cap_addr.push_back(bus.CMD_ADDR);
                cap_data.push_back(bus.CMD_DATA);
            end
            if (bus.FRAME_ERR) err_codes.push_back(bus.FRAME_ERR_CODE);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.DATA_STREAM_IN     = b;
        bus.DATA_STREAM_IN_STB = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge sys_clk);
            if (bus.DATA_STREAM_IN_ACK) break;
            if (n >= 2000) begin
                checks++;
                errors++;
                $display("FAIL ack_wait actual=no_ack required=ack within 2000 cycles at %0t", $time);
                break;
            end
        end
        @(posedge sys_clk);
        #1;
        bus.DATA_STREAM_IN_STB = 1'b0;
    endtask

    // Sends the first n bytes of f, most significant byte first.
    task automatic send_bytes(input logic [79:0] f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[79-8*i -: 8]);
    endtask

    task automatic clear_obs();
        cap_wr.delete(); cap_addr.delete(); cap_data.delete(); err_codes.delete();
    endtask

    task automatic check_cmds(input string tag, input int n, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_ncmd"}, 32'(cap_wr.size()), 32'(n));
        if (cap_wr.size() > 0) begin
            chk({tag, "_wr"}, 32'(cap_wr[$]), 32'(wr));
            chk({tag, "_addr"}, cap_addr[$], addr);
            chk({tag, "_data"}, cap_data[$], data);
        end
    endtask

    initial begin
        bus.DATA_STREAM_IN     = 8'h00;
        bus.DATA_STREAM_IN_STB = 1'b0;
        bus.CMD_READY          = 1'b1;
        idle(3);
        sys_rst = 1'b1;
        idle(2);

        // write frame
        clear_obs();
        send_bytes(WR_FRAME, 10);
        idle(3);
        check_cmds("wr", 1, 1'b1, 32'hAABBCCDD, 32'h11223344);
        chk("wr_nerr", 32'(err_codes.size()), 32'd0);

        // read frame: received data bytes are discarded
        clear_obs();
        send_bytes(RD_FRAME, 10);
        idle(3);
        check_cmds("rd", 1, 1'b0, 32'h12345678, 32'h00000000);

        // two bad headers then a good frame
        clear_obs();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_bytes(WR_FRAME, 10);
        idle(3);
        chk("hdr_nerr", 32'(err_codes.size()), 32'd2);
        if (err_codes.size() == 2) begin
            chk("hdr_code0", 32'(err_codes[0]), 32'h1);
            chk("hdr_code1", 32'(err_codes[1]), 32'h1);
        end
        check_cmds("hdr", 1, 1'b1, 32'hAABBCCDD, 32'h11223344);

        // bad tail
        clear_obs();
        send_bytes(BAD_TAIL, 10);
        idle(3);
        chk("tail_ncmd", 32'(cap_wr.size()), 32'd0);
        chk("tail_nerr", 32'(err_codes.size()), 32'd1);
        if (err_codes.size() == 1) chk("tail_code", 32'(err_codes[0]), 32'h2);

        // stall after two bytes for five pulse periods, then a good frame
        clear_obs();
        send_bytes(WR_FRAME, 2);
        idle(5 * 2 * PULSE_HALF);
        chk("tmo_nerr", 32'(err_codes.size()), 32'd1);
        if (err_codes.size() == 1) chk("tmo_code", 32'(err_codes[0]), 32'h3);
        send_bytes(RD_FRAME, 10);
        idle(3);
        check_cmds("tmo", 1, 1'b0, 32'h12345678, 32'h00000000);

        // executor stall with the next header byte queued
        clear_obs();
        bus.CMD_READY = 1'b0;
        send_bytes(WR_FRAME, 10);
        bus.DATA_STREAM_IN     = 8'h5A;
        bus.DATA_STREAM_IN_STB = 1'b1;
        idle(1000);
        @(negedge sys_clk);
        chk("bp_ack", 32'(bus.DATA_STREAM_IN_ACK), 32'h0);
        chk("bp_valid", 32'(bus.CMD_VALID), 32'h1);
        chk("bp_addr", bus.CMD_ADDR, 32'hAABBCCDD);
        chk("bp_data", bus.CMD_DATA, 32'h11223344);
        @(posedge sys_clk);
        #1 bus.CMD_READY = 1'b1;
        @(negedge sys_clk);
        chk("bp_valid_hs", 32'(bus.CMD_VALID), 32'h1);
        @(negedge sys_clk);
        chk("bp_valid_drop", 32'(bus.CMD_VALID), 32'h0);
        chk("bp_ack_rise", 32'(bus.DATA_STREAM_IN_ACK), 32'h1);
        @(posedge sys_clk);
        #1 bus.DATA_STREAM_IN_STB = 1'b0;
        check_cmds("bp1", 1, 1'b1, 32'hAABBCCDD, 32'h11223344);
        send_bytes({WR_FRAME[71:0], 8'h00}, 9);
        idle(3);
        check_cmds("bp2", 2, 1'b1, 32'hAABBCCDD, 32'h11223344);
        chk("bp_nerr", 32'(err_codes.size()), 32'd0);

        // reset after byte 6 of a frame
        send_bytes(WR_FRAME, 6);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_ack", 32'(bus.DATA_STREAM_IN_ACK), 32'h1);
        chk("rst_valid", 32'(bus.CMD_VALID), 32'h0);
        chk("rst_err", 32'(bus.FRAME_ERR), 32'h0);
        chk("rst_code", 32'(bus.FRAME_ERR_CODE), 32'h0);
        idle(2);
        sys_rst = 1'b1;
        idle(2);
        clear_obs();
        send_bytes(WR_FRAME, 10);
        idle(3);
        check_cmds("post_rst", 1, 1'b1, 32'hAABBCCDD, 32'h11223344);
        chk("post_rst_nerr", 32'(err_codes.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
